uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- 16x-oversampled UART receiver; the far end of the team's UART transmitter, one frame per byte.
- Fully synchronous to CLK. The oversample strobe TICK (from the baud generator) is a clock enable, not a clock.
- Majority-vote bit sampling, configurable parity, framing/break detection, valid/ready output with overrun flag.
- Sits between the pad-side RX line and the byte consumer (register file or FIFO).

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- OVERSAMPLE, 16, TICKs per bit time (even, >=8).
- PARITY_EN, 1, 1 = parity bit present between data and stop.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  reset, synchronous, active-low.
- TICK  in  1  one-CLK-wide oversample strobe, OVERSAMPLE per bit time.
- RXD  in  1  asynchronous serial line, idle high.
- DOUT  out  DATA_BITS  received data word.
- DVALID  out  1  DOUT/PERR/FERR valid.
- DREADY  in  1  consumer accepts when DVALID&&DREADY.
- PERR  out  1  parity error for the word on DOUT.
- FERR  out  1  stop bit sampled 0 for the word on DOUT.
- OVR  out  1  one-CLK pulse: completed frame dropped because DVALID was still high.
- BRK  out  1  one-CLK pulse: break detected.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESETN=0 at a CLK edge):
  - Synchronizer flops reset to 1; state=IDLE.
  - DOUT=0, DVALID=PERR=FERR=OVR=BRK=BUSY=0.
  - Reset mid-frame abandons the frame; no partial output.
- Synchronizer: RXD passes through 2 flops to give rxs. All decisions use rxs; the 2-CLK latency is accepted.
- All counters and state advance only on CLK edges with TICK=1. OVR and BRK pulses, and handshake clearing, are not TICK-gated.
- Bit counter cnt runs 0..OVERSAMPLE-1. M = OVERSAMPLE/2.
- Majority vote: samples taken at cnt = M-1, M, M+1; bit value = 2-of-3.
- States:
  - IDLE: on TICK with rxs=0, go to START with cnt=1 (that tick counts as cnt 0).
  - START: at cnt=M+1, if the vote is 1 it is a false start: go to IDLE, no flags. At cnt=OVERSAMPLE-1, go to DATA with cnt=0 and bit index=0.
  - DATA: at cnt=M+1, shift the vote into the shift register at the current bit index (LSB first). At cnt=OVERSAMPLE-1, increment the index; after DATA_BITS bits go to PARITY if PARITY_EN, else to STOP.
  - PARITY: at cnt=M+1, store the vote. Expected parity = XOR(data) ^ PARITY_ODD. At cnt=OVERSAMPLE-1, go to STOP.
  - STOP: evaluated at cnt=M+1, half a bit early, for resync margin.
    - vote=1: deliver the word, go to IDLE.
    - vote=0 and data and parity all 0: BRK pulse, no delivery, go to WAIT_HI.
    - vote=0 otherwise: deliver with FERR=1, go to WAIT_HI.
  - WAIT_HI: on TICK with rxs=1, go to IDLE.
- Delivery:
  - If DVALID=0: on the same edge, DOUT<=shift register, PERR<=(parity mismatch && PARITY_EN), FERR as above, DVALID<=1.
  - If DVALID=1: the frame is discarded; DOUT/PERR/FERR are kept; OVR pulses one CLK.
  - Consumer accepts on DVALID&&DREADY: DVALID<=0 the next edge.
  - Acceptance and a new delivery on the same edge: the new word loads, DVALID stays 1, no OVR.
- DOUT, PERR and FERR are stable while DVALID=1.

Decomposition:
- uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HI);
  - default OVERSAMPLE = 16;
  - parity mode constants.
- One sub-module, uart_rx_sampler: 2-flop synchronizer, TICK-gated cnt, 3-sample majority vote. It outputs rxs, cnt, vote, and a sample_done strobe at cnt=M+1.

Test Plan:
- Basic frame: TICK every 4 CLK, DATA_BITS=8, even parity. Send 0xA5, parity 0, stop 1, DREADY=1 -> DOUT=0xA5, DVALID for 1 cycle, PERR=FERR=0, BUSY falls 1 cycle after delivery.
- Parity error: send 0x3C with parity bit 1 -> DOUT=0x3C, PERR=1, FERR=0. Same test with PARITY_EN=0 and no parity bit -> PERR=0.
- False start and majority vote:
  - RXD low for 4 ticks, then high -> no DVALID, state returns to IDLE, BUSY drops.
  - One-tick high glitch at cnt=M inside data bit 3 of 0x00 -> DOUT=0x00.
- Overrun: DREADY=0, send 0x11 then 0x22 -> DOUT remains 0x11, OVR pulses exactly once. Raise DREADY -> DVALID falls next edge.
- Break and framing:
  - RXD low for 12 bit times -> single BRK pulse, no DVALID, BUSY held until RXD high, then IDLE.
  - Send 0x55 with stop=0 -> DOUT=0x55, FERR=1.
- Reset mid-frame: RESETN=0 for 1 CLK during data bit 4 -> all outputs 0, state IDLE. A following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the oversampled receiver and its sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer, TICK-gated bit-phase counter and 2-of-3 vote.
// Counter parks at 1 while not running so the start-detect tick is cnt 0.
import uart_pkg::*;

module uart_rx_sampler #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int CW = $clog2(OVERSAMPLE)
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          TICK,
  input  logic          RXD,
  input  logic          run,
  output logic          rxs,
  output logic [CW-1:0] cnt,
  output logic          vote,
  output logic          sample_done
);

  localparam int M = OVERSAMPLE / 2;

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s0_q, s0_d;
  logic          s1_q, s1_d;

  assign rxs = sync_q[1];
  assign cnt = cnt_q;

  always_comb begin
    sync_d = {sync_q[0], RXD};
    cnt_d  = cnt_q;
    s0_d   = s0_q;
    s1_d   = s1_q;
    if (TICK) begin
      if (!run)
        cnt_d = CW'(1);
      else if (cnt_q == CW'(OVERSAMPLE - 1))
        cnt_d = '0;
      else
        cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(M - 1)) s0_d = rxs;
      if (cnt_q == CW'(M))     s1_d = rxs;
    end
  end

  assign vote = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign sample_done = TICK && run && (cnt_q == CW'(M + 1));

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver with parity, framing/break detection
// and a valid/ready output holding one word plus an overrun pulse.
import uart_pkg::*;

module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 TICK,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 DVALID,
  input  logic                 DREADY,
  output logic                 PERR,
  output logic                 FERR,
  output logic                 OVR,
  output logic                 BRK,
  output logic                 BUSY
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  rx_state_e            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 brk_q, brk_d;

  logic          rxs, vote, sample_done, run, last;
  logic [CW-1:0] cnt;
  logic          deliver, ferr_new, perr_new, accept;

  assign run = (state_q == START) || (state_q == DATA) ||
               (state_q == PARITY) || (state_q == STOP);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .TICK        (TICK),
    .RXD         (RXD),
    .run         (run),
    .rxs         (rxs),
    .cnt         (cnt),
    .vote        (vote),
    .sample_done (sample_done)
  );

  assign last     = TICK && (cnt == CW'(OVERSAMPLE - 1));
  assign accept   = dvalid_q && DREADY;
  assign perr_new = PARITY_EN &&
                    (par_q != ((^shreg_q) ^ PARITY_ODD));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    deliver  = 1'b0;
    ferr_new = 1'b0;
    brk_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TICK && !rxs) begin
          state_d = START;
          par_d   = 1'b0;
        end
      end
      START: begin
        if (sample_done && vote) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (sample_done) shreg_d[idx_q] = vote;
        if (last) begin
          if (idx_q == IW'(DATA_BITS - 1))
            state_d = PARITY_EN ? PARITY : STOP;
          else
            idx_d = idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (sample_done) par_d = vote;
        if (last) state_d = STOP;
      end
      STOP: begin
        // Decided at mid-bit so the next start edge is never missed
        if (sample_done) begin
          if (vote) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else if (shreg_q == '0 && !par_q) begin
            brk_d   = 1'b1;
            state_d = WAIT_HI;
          end else begin
            deliver  = 1'b1;
            ferr_new = 1'b1;
            state_d  = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (TICK && rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovr_d    = 1'b0;
    if (deliver && (!dvalid_q || accept)) begin
      dout_d   = shreg_q;
      perr_d   = perr_new;
      ferr_d   = ferr_new;
      dvalid_d = 1'b1;
    end else if (deliver) begin
      ovr_d = 1'b1;
    end else if (accept) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      brk_q    <= brk_d;
    end
  end

  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign PERR   = perr_q;
  assign FERR   = ferr_q;
  assign OVR    = ovr_q;
  assign BRK    = brk_q;
  assign BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: even-parity and no-parity instances,
// TICK every 4 CLK, frames driven bit by bit on TICK boundaries.
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] tdiv = 2'd0;

  logic       rxd = 1'b1;
  logic       dready = 1'b1;
  logic [7:0] dout;
  logic       dvalid, perr, ferr, ovr, brk, busy;

  logic       rxd_np = 1'b1;
  logic       dready_np = 1'b0;
  logic [7:0] dout_np;
  logic       dvalid_np, perr_np, ferr_np;
  logic       ovr_np, brk_np, busy_np;

  int n_chk = 0;
  int n_fail = 0;

  int acc_cnt = 0;
  int dv_cyc = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  logic [7:0] last_dout = 8'h00;
  logic last_perr = 1'b0;
  logic last_ferr = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tdiv <= tdiv + 2'd1;
    tick <= (tdiv == 2'd3);
  end

  uart_rx_os #(
    .DATA_BITS (8), .OVERSAMPLE (16),
    .PARITY_EN (1'b1), .PARITY_ODD (1'b0)
  ) u_dut (
    .CLK (clk), .RESETN (rstn), .TICK (tick),
    .RXD (rxd), .DOUT (dout), .DVALID (dvalid),
    .DREADY (dready), .PERR (perr), .FERR (ferr),
    .OVR (ovr), .BRK (brk), .BUSY (busy)
  );

  uart_rx_os #(
    .DATA_BITS (8), .OVERSAMPLE (16),
    .PARITY_EN (1'b0), .PARITY_ODD (1'b0)
  ) u_dut_np (
    .CLK (clk), .RESETN (rstn), .TICK (tick),
    .RXD (rxd_np), .DOUT (dout_np),
    .DVALID (dvalid_np), .DREADY (dready_np),
    .PERR (perr_np), .FERR (ferr_np),
    .OVR (ovr_np), .BRK (brk_np), .BUSY (busy_np)
  );

  always @(negedge clk) begin
    if (dvalid) dv_cyc <= dv_cyc + 1;
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    if (brk) brk_cnt <= brk_cnt + 1;
    if (dvalid && dready) begin
      acc_cnt   <= acc_cnt + 1;
      last_dout <= dout;
      last_perr <= perr;
      last_ferr <= ferr;
    end
  end

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    @(posedge clk iff tick);
    #1;
  endtask

  task automatic drive_bit(input bit np, input logic v);
    if (np) rxd_np = v;
    else rxd = v;
    repeat (16) wait_tick();
  endtask

  task automatic glitch_bit();
    rxd = 1'b0;
    repeat (8) wait_tick();
    rxd = 1'b1;
    wait_tick();
    rxd = 1'b0;
    repeat (7) wait_tick();
  endtask

  task automatic send(input bit np, input logic [7:0] d,
                      input logic par, input logic stp,
                      input bit glitch);
    drive_bit(np, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (glitch && i == 3) glitch_bit();
      else drive_bit(np, d[i]);
    end
    if (!np) drive_bit(np, par);
    drive_bit(np, stp);
    if (np) rxd_np = 1'b1;
    else rxd = 1'b1;
    repeat (4) wait_tick();
  endtask

  int a0, c0, o0, b0;

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rst_dout", {24'd0, dout}, 32'h0);
    check_eq("rst_dvalid", {31'd0, dvalid}, 32'h0);
    check_eq("rst_perr", {31'd0, perr}, 32'h0);
    check_eq("rst_ferr", {31'd0, ferr}, 32'h0);
    check_eq("rst_busy", {31'd0, busy}, 32'h0);
    repeat (4) wait_tick();

    a0 = acc_cnt; c0 = dv_cyc;
    send(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
    check_eq("a5_cnt", acc_cnt - a0, 1);
    check_eq("a5_dvcyc", dv_cyc - c0, 1);
    check_eq("a5_dout", {24'd0, last_dout}, 32'hA5);
    check_eq("a5_perr", {31'd0, last_perr}, 32'h0);
    check_eq("a5_ferr", {31'd0, last_ferr}, 32'h0);
    check_eq("a5_busy", {31'd0, busy}, 32'h0);
    check_eq("a5_hold", {24'd0, dout}, 32'hA5);

    a0 = acc_cnt;
    send(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0);
    check_eq("3c_cnt", acc_cnt - a0, 1);
    check_eq("3c_dout", {24'd0, last_dout}, 32'h3C);
    check_eq("3c_perr", {31'd0, last_perr}, 32'h1);
    check_eq("3c_ferr", {31'd0, last_ferr}, 32'h0);

    send(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    check_eq("np_dvalid", {31'd0, dvalid_np}, 32'h1);
    check_eq("np_dout", {24'd0, dout_np}, 32'h3C);
    check_eq("np_perr", {31'd0, perr_np}, 32'h0);

    a0 = acc_cnt;
    rxd = 1'b0;
    repeat (4) wait_tick();
    rxd = 1'b1;
    check_eq("fs_busy_hi", {31'd0, busy}, 32'h1);
    repeat (24) wait_tick();
    check_eq("fs_busy_lo", {31'd0, busy}, 32'h0);
    check_eq("fs_nodv", acc_cnt - a0, 0);

    a0 = acc_cnt;
    send(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check_eq("gl_cnt", acc_cnt - a0, 1);
    check_eq("gl_dout", {24'd0, last_dout}, 32'h00);
    check_eq("gl_perr", {31'd0, last_perr}, 32'h0);

    dready = 1'b0;
    o0 = ovr_cnt;
    send(1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
    send(1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
    check_eq("ovr_dout", {24'd0, dout}, 32'h11);
    check_eq("ovr_dvalid", {31'd0, dvalid}, 32'h1);
    check_eq("ovr_pulses", ovr_cnt - o0, 1);
    @(negedge clk);
    dready = 1'b1;
    @(negedge clk);
    check_eq("ovr_drop", {31'd0, dvalid}, 32'h0);
    check_eq("ovr_last", {24'd0, last_dout}, 32'h11);

    a0 = acc_cnt; b0 = brk_cnt;
    rxd = 1'b0;
    repeat (12 * 16) wait_tick();
    check_eq("brk_pulses", brk_cnt - b0, 1);
    check_eq("brk_nodv", acc_cnt - a0, 0);
    check_eq("brk_busy", {31'd0, busy}, 32'h1);
    rxd = 1'b1;
    repeat (4) wait_tick();
    check_eq("brk_idle", {31'd0, busy}, 32'h0);

    a0 = acc_cnt;
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    check_eq("fe_cnt", acc_cnt - a0, 1);
    check_eq("fe_dout", {24'd0, last_dout}, 32'h55);
    check_eq("fe_ferr", {31'd0, last_ferr}, 32'h1);
    check_eq("fe_busy", {31'd0, busy}, 32'h0);

    a0 = acc_cnt;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    rxd = 1'b0;
    repeat (8) wait_tick();
    check_eq("mr_busy_pre", {31'd0, busy}, 32'h1);
    rxd = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_eq("mr_dout", {24'd0, dout}, 32'h0);
    check_eq("mr_ferr", {31'd0, ferr}, 32'h0);
    check_eq("mr_dvalid", {31'd0, dvalid}, 32'h0);
    check_eq("mr_busy", {31'd0, busy}, 32'h0);
    repeat (40) wait_tick();
    check_eq("mr_nodv", acc_cnt - a0, 0);

    a0 = acc_cnt;
    send(1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
    check_eq("81_cnt", acc_cnt - a0, 1);
    check_eq("81_dout", {24'd0, last_dout}, 32'h81);
    check_eq("81_perr", {31'd0, last_perr}, 32'h0);
    check_eq("81_ferr", {31'd0, last_ferr}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
